// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Issues one divide at a time to the signed/unsigned AXI-stream
//            divider IPs, holds the selected result, drains flushed results.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [XLEN-1:0]     req_src1,
    input  logic [XLEN-1:0]     req_src2,
    input  logic                cancel,
    output logic                res_valid,
    input  logic                res_ack,
    output logic [XLEN-1:0]     res_data,
    output logic                busy,
    output logic [XLEN-1:0]     div_dividend,
    output logic [XLEN-1:0]     div_divisor,
    output logic                s_dvnd_tvalid,
    output logic                s_dvsr_tvalid,
    input  logic                s_dvnd_tready,
    input  logic                s_dvsr_tready,
    input  logic                s_dout_tvalid,
    input  logic [2*XLEN-1:0]   s_dout,
    output logic                u_dvnd_tvalid,
    output logic                u_dvsr_tvalid,
    input  logic                u_dvnd_tready,
    input  logic                u_dvsr_tready,
    input  logic                u_dout_tvalid,
    input  logic [2*XLEN-1:0]   u_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state;
    logic   use_signed;
    logic   is_mod;
    logic   dvnd_acc;
    logic   dvsr_acc;

    logic              w_driving;
    logic              w_dvnd_vld;
    logic              w_dvsr_vld;
    logic              w_dvnd_hs;
    logic              w_dvsr_hs;
    logic              w_dvnd_done;
    logic              w_dvsr_done;
    logic              w_dout_vld;
    logic [2*XLEN-1:0] w_dout;
    logic [XLEN-1:0]   w_sel;

    // Unaccepted channels keep driving in DRAIN so the IP never sees a half request.
    assign w_driving   = (state == ISSUE) || (state == DRAIN);
    assign w_dvnd_vld  = w_driving & ~dvnd_acc;
    assign w_dvsr_vld  = w_driving & ~dvsr_acc;

    assign s_dvnd_tvalid = w_dvnd_vld &  use_signed;
    assign s_dvsr_tvalid = w_dvsr_vld &  use_signed;
    assign u_dvnd_tvalid = w_dvnd_vld & ~use_signed;
    assign u_dvsr_tvalid = w_dvsr_vld & ~use_signed;

    assign w_dvnd_hs   = w_dvnd_vld & (use_signed ? s_dvnd_tready : u_dvnd_tready);
    assign w_dvsr_hs   = w_dvsr_vld & (use_signed ? s_dvsr_tready : u_dvsr_tready);
    assign w_dvnd_done = dvnd_acc | w_dvnd_hs;
    assign w_dvsr_done = dvsr_acc | w_dvsr_hs;

    assign w_dout_vld  = use_signed ? s_dout_tvalid : u_dout_tvalid;
    assign w_dout      = use_signed ? s_dout : u_dout;
    assign w_sel       = is_mod ? w_dout[XLEN-1:0] : w_dout[2*XLEN-1:XLEN];

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            use_signed   <= 1'b0;
            is_mod       <= 1'b0;
            dvnd_acc     <= 1'b0;
            dvsr_acc     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !cancel) begin
                        div_dividend <= req_src1;
                        div_divisor  <= req_src2;
                        use_signed   <= req_op[0] | req_op[1];
                        // A mod op has a mod bit set and no div bit set.
                        is_mod       <= (req_op[1] | req_op[3]) & ~(req_op[0] | req_op[2]);
                        dvnd_acc     <= 1'b0;
                        dvsr_acc     <= 1'b0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    dvnd_acc <= w_dvnd_done;
                    dvsr_acc <= w_dvsr_done;
                    if (cancel) begin
                        state <= (!w_dvnd_done && !w_dvsr_done) ? IDLE : DRAIN;
                    end else if (w_dvnd_done && w_dvsr_done) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cancel) begin
                        state <= w_dout_vld ? IDLE : DRAIN;
                    end else if (w_dout_vld) begin
                        res_data  <= w_sel;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ack || cancel) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    dvnd_acc <= w_dvnd_done;
                    dvsr_acc <= w_dvsr_done;
                    // Only a result produced after both operands went out belongs to us.
                    if (dvnd_acc && dvsr_acc && w_dout_vld) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Self-checking bench for div_issue_ctrl with divider IP models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, cancel, res_valid, res_ack, busy;
    logic [3:0]  req_op;
    logic [31:0] req_src1, req_src2, res_data, div_dividend, div_divisor;
    logic        s_dvnd_tvalid, s_dvsr_tvalid, s_dvnd_tready, s_dvsr_tready, s_dout_tvalid;
    logic        u_dvnd_tvalid, u_dvsr_tvalid, u_dvnd_tready, u_dvsr_tready, u_dout_tvalid;
    logic [63:0] s_dout, u_dout;

    always #5 clk = ~clk;

    div_issue_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .cancel(cancel),
        .res_valid(res_valid), .res_ack(res_ack), .res_data(res_data), .busy(busy),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .s_dvnd_tvalid(s_dvnd_tvalid), .s_dvsr_tvalid(s_dvsr_tvalid),
        .s_dvnd_tready(s_dvnd_tready), .s_dvsr_tready(s_dvsr_tready),
        .s_dout_tvalid(s_dout_tvalid), .s_dout(s_dout),
        .u_dvnd_tvalid(u_dvnd_tvalid), .u_dvsr_tvalid(u_dvsr_tvalid),
        .u_dvnd_tready(u_dvnd_tready), .u_dvsr_tready(u_dvsr_tready),
        .u_dout_tvalid(u_dout_tvalid), .u_dout(u_dout)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one outstanding divide described by progress flags.
    bit          m_busy, m_sgn, m_mod, m_ddone, m_vdone, m_drain, m_held;
    logic [31:0] m_a, m_b, m_res;

    // Divider IP models (index 0 = signed, 1 = unsigned).
    bit          ip_gd[2], ip_gv[2], ip_pend[2], ip_out[2];
    logic [31:0] ip_a[2], ip_b[2];
    logic [63:0] ip_res[2];
    int          ip_cnt[2];
    int          lat_cfg;
    bit          glitch_en, force_sglitch;

    int ncyc, n_sdvnd, n_sdvsr, n_udvnd, n_udvsr, n_rv, n_hs, t0, hs0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ip_calc(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
            sa = int'(a);
            sb = int'(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic drive_ip();
        for (int u = 0; u < 2; u++) begin
            logic        tv;
            logic [63:0] d;
            ip_out[u] = ip_pend[u] && (ip_cnt[u] == 0);
            tv = ip_out[u];
            d  = ip_out[u] ? ip_res[u] : 64'h0;
            if (!ip_pend[u] && glitch_en && (!m_busy || (m_sgn != (u == 0)))
                && $urandom_range(0, 3) == 0) begin
                tv = 1'b1;
                d  = {$urandom, $urandom};
            end
            if (u == 0) begin s_dout_tvalid = tv; s_dout = d; end
            else        begin u_dout_tvalid = tv; u_dout = d; end
        end
        if (force_sglitch) begin
            s_dout_tvalid = 1'b1;
            s_dout        = 64'hDEAD_BEEF_0BAD_F00D;
        end
    endtask

    task automatic ip_update();
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                ip_gd[u] = 0; ip_gv[u] = 0; ip_pend[u] = 0;
            end
            return;
        end
        for (int u = 0; u < 2; u++) begin
            bit dh, vh;
            dh = (u == 0) ? (s_dvnd_tvalid && s_dvnd_tready) : (u_dvnd_tvalid && u_dvnd_tready);
            vh = (u == 0) ? (s_dvsr_tvalid && s_dvsr_tready) : (u_dvsr_tvalid && u_dvsr_tready);
            if (dh) begin ip_gd[u] = 1; ip_a[u] = div_dividend; n_hs++; end
            if (vh) begin ip_gv[u] = 1; ip_b[u] = div_divisor;  n_hs++; end
            if (ip_out[u]) ip_pend[u] = 0;
            else if (ip_pend[u] && ip_cnt[u] > 0) ip_cnt[u]--;
            if (ip_gd[u] && ip_gv[u]) begin
                ip_pend[u] = 1;
                ip_cnt[u]  = ((lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 10))) - 1;
                ip_res[u]  = ip_calc(u == 0, ip_a[u], ip_b[u]);
                ip_gd[u]   = 0;
                ip_gv[u]   = 0;
            end
        end
    endtask

    task automatic model_update();
        bit dout, hd, hv, nd, nv, both;
        logic [63:0] dval;
        if (reset) begin
            m_busy = 0; m_held = 0; m_drain = 0; m_ddone = 0; m_vdone = 0;
            return;
        end
        if (!m_busy) begin
            if (req_valid && !cancel) begin
                m_busy = 1; m_sgn = req_op[0] | req_op[1]; m_mod = req_op[1] | req_op[3];
                m_a = req_src1; m_b = req_src2;
                m_ddone = 0; m_vdone = 0; m_drain = 0; m_held = 0;
            end
        end else if (m_held) begin
            if (res_ack || cancel) begin m_busy = 0; m_held = 0; end
        end else begin
            dout = m_sgn ? s_dout_tvalid : u_dout_tvalid;
            hd   = !m_ddone && (m_sgn ? s_dvnd_tready : u_dvnd_tready);
            hv   = !m_vdone && (m_sgn ? s_dvsr_tready : u_dvsr_tready);
            both = m_ddone && m_vdone;
            nd   = m_ddone || hd;
            nv   = m_vdone || hv;
            if (m_drain) begin
                if (both && dout) begin m_busy = 0; m_drain = 0; end
            end else if (cancel) begin
                if (!nd && !nv)        m_busy = 0;
                else if (both && dout) m_busy = 0;
                else                   m_drain = 1;
            end else if (both && dout) begin
                m_held = 1;
                dval   = ip_calc(m_sgn, m_a, m_b);
                m_res  = m_mod ? dval[31:0] : dval[63:32];
            end
            m_ddone = nd;
            m_vdone = nv;
        end
    endtask

    task automatic compare();
        ncyc++;
        chk("req_ready", req_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("res_valid", res_valid, m_held);
        chk("s_dvnd_tvalid", s_dvnd_tvalid, m_busy && !m_ddone && m_sgn);
        chk("s_dvsr_tvalid", s_dvsr_tvalid, m_busy && !m_vdone && m_sgn);
        chk("u_dvnd_tvalid", u_dvnd_tvalid, m_busy && !m_ddone && !m_sgn);
        chk("u_dvsr_tvalid", u_dvsr_tvalid, m_busy && !m_vdone && !m_sgn);
        chk("tvalid_exclusive", (s_dvnd_tvalid | s_dvsr_tvalid) & (u_dvnd_tvalid | u_dvsr_tvalid), 0);
        if (m_held) chk("res_data", res_data, m_res);
        if (m_busy && (!m_ddone || !m_vdone)) begin
            chk("div_dividend", div_dividend, m_a);
            chk("div_divisor", div_divisor, m_b);
        end
        n_sdvnd += int'(s_dvnd_tvalid); n_sdvsr += int'(s_dvsr_tvalid);
        n_udvnd += int'(u_dvnd_tvalid); n_udvsr += int'(u_dvsr_tvalid);
        n_rv    += int'(res_valid);
    endtask

    task automatic cyc();
        drive_ip();
        #1;
        model_update();
        ip_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic clr_counts();
        n_sdvnd = 0; n_sdvsr = 0; n_udvnd = 0; n_udvsr = 0; n_rv = 0;
    endtask

    task automatic set_rdy(input logic v);
        s_dvnd_tready = v; s_dvsr_tready = v; u_dvnd_tready = v; u_dvsr_tready = v;
    endtask

    task automatic start_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        t0 = ncyc;
        cyc();
        req_valid = 0;
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!res_valid && n < 40) begin cyc(); n++; end
        chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin cyc(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic ack();
        res_ack = 1; cyc(); res_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; req_valid = 0; req_op = 4'b0001; req_src1 = 0; req_src2 = 0;
        cancel = 0; res_ack = 0; set_rdy(1'b1);
        lat_cfg = 8; glitch_en = 0; force_sglitch = 0;
        ncyc = 0; n_hs = 0; clr_counts();
        cyc(); cyc();
        chk("rst_res_data", res_data, 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        reset = 0;
        cyc();

        // div.w -7 / 2 with an 8-cycle IP
        clr_counts();
        start_req(4'b0001, 32'hFFFF_FFF9, 32'd2);
        wait_rv();
        chk("divw_latency", ncyc - t0, 10);
        chk("divw_result", res_data, 32'hFFFF_FFFD);
        chk("divw_s_dvnd_cycles", n_sdvnd, 1);
        chk("divw_s_dvsr_cycles", n_sdvsr, 1);
        chk("divw_u_tvalid_cycles", n_udvnd + n_udvsr, 0);
        ack();
        chk("divw_busy_after_ack", busy, 0);

        // mod.wu 0xFFFFFFFF % 10 with a signed-unit glitch during WAIT
        clr_counts();
        start_req(4'b1000, 32'hFFFF_FFFF, 32'd10);
        cyc();
        force_sglitch = 1; cyc(); force_sglitch = 0;
        wait_rv();
        chk("modwu_result", res_data, 32'd5);
        chk("modwu_s_tvalid_cycles", n_sdvnd + n_sdvsr, 0);
        chk("modwu_u_dvnd_cycles", n_udvnd, 1);
        ack();

        // Divisor backpressure for 3 cycles
        clr_counts();
        start_req(4'b0001, 32'd77, 32'd7);
        s_dvsr_tready = 0;
        cyc(); cyc(); cyc();
        s_dvsr_tready = 1;
        wait_rv();
        chk("bp_s_dvnd_cycles", n_sdvnd, 1);
        chk("bp_s_dvsr_cycles", n_sdvsr, 4);
        chk("bp_latency", ncyc - t0, 13);
        chk("bp_result", res_data, 32'd11);
        ack();

        // Cancel in the third WAIT cycle, then a fresh 100/7
        clr_counts();
        start_req(4'b0001, 32'd50, 32'd3);
        cyc(); cyc(); cyc();
        cancel = 1; req_valid = 1; req_op = 4'b0001; req_src1 = 32'd100; req_src2 = 32'd7;
        cyc();
        cancel = 0;
        chk("drain_req_ready", req_ready, 0);
        chk("drain_busy", busy, 1);
        wait_idle();
        chk("drain_no_res_valid", n_rv, 0);
        start_req(4'b0001, 32'd100, 32'd7);
        wait_rv();
        chk("after_drain_result", res_data, 32'd14);
        ack();

        // Cancel in ISSUE with only the divisor accepted
        clr_counts();
        s_dvnd_tready = 0;
        start_req(4'b0001, 32'd1000, 32'd10);
        cyc();
        cancel = 1; cyc(); cancel = 0;
        chk("issue_cancel_busy", busy, 1);
        chk("issue_cancel_dvnd_held", s_dvnd_tvalid, 1);
        chk("issue_cancel_dvsr_low", s_dvsr_tvalid, 0);
        cyc(); cyc();
        s_dvnd_tready = 1;
        wait_idle();
        chk("issue_cancel_no_res", n_rv, 0);

        // Cancel with nothing accepted
        set_rdy(1'b0);
        hs0 = n_hs;
        start_req(4'b0100, 32'd9, 32'd3);
        cancel = 1; cyc(); cancel = 0;
        chk("cancel_nothing_idle", busy, 0);
        chk("cancel_nothing_hs", n_hs - hs0, 0);
        set_rdy(1'b1);
        cyc();

        // Reset while in WAIT
        start_req(4'b0010, 32'd123, 32'd4);
        cyc(); cyc();
        reset = 1; cyc(); reset = 0;
        chk("wait_rst_busy", busy, 0);
        chk("wait_rst_res_data", res_data, 0);
        chk("wait_rst_dividend", div_dividend, 0);
        chk("wait_rst_tvalids", {s_dvnd_tvalid, s_dvsr_tvalid, u_dvnd_tvalid, u_dvsr_tvalid}, 0);

        // req_valid with cancel in the same IDLE cycle is refused
        req_valid = 1; cancel = 1; cyc(); req_valid = 0; cancel = 0;
        chk("req_with_cancel_refused", busy, 0);
        cyc();

        // Randomized traffic
        lat_cfg = 0; glitch_en = 1;
        for (int i = 0; i < 4000; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_op    = 4'(1 << $urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       req_src1 = $urandom;
                1:       req_src1 = $urandom_range(0, 200);
                default: req_src1 = 32'hFFFF_FFFF - $urandom_range(0, 200);
            endcase
            case ($urandom_range(0, 9))
                0:       req_src2 = 32'h0;
                1:       req_src2 = 32'hFFFF_FFFF;
                2, 3:    req_src2 = $urandom;
                default: req_src2 = $urandom_range(1, 20);
            endcase
            cancel  = ($urandom_range(0, 99) < 6);
            res_ack = ($urandom_range(0, 99) < 40);
            reset   = ($urandom_range(0, 999) < 3);
            s_dvnd_tready = ($urandom_range(0, 9) < 7);
            s_dvsr_tready = ($urandom_range(0, 9) < 7);
            u_dvnd_tready = ($urandom_range(0, 9) < 7);
            u_dvsr_tready = ($urandom_range(0, 9) < 7);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
